uart_tnsm_fifo: RTL and testbench
=================================

Name: uart_tnsm_fifo

Overview:
Second-generation UART transmitter with a parametrised data width and a built-in synchronous TX FIFO.
- Per-frame data length, parity (none/odd/even/mark) and 1 or 2 stop bits.
- Back-to-back frames with no idle gap, plus a line-break generator.
- Sits between the register/bus interface and the tx pad. Bit timing comes from the shared baud generator via tnsm_clk_en: one pulse per bit period.

Parameters:
- DATA_MAX, 9, maximum data bits per frame; legal range 5..9.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the level output (derived).

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous active-high reset
- active  in  1  transmitter enable; low aborts any frame in progress
- wr_en  in  1  FIFO write strobe
- wr_data  in  DATA_MAX  frame payload, LSB first on line
- data_len  in  4  data bits per frame
- parity_type  in  2  00 none, 01 odd, 10 even, 11 mark (parity bit = 1)
- stop_type  in  1  0 = one stop bit, 1 = two stop bits
- break_req  in  1  hold line low (break) while high
- tnsm_clk_en  in  1  bit-rate enable pulse
- tx  out  1  serial line, idle high
- busy  out  1  FSM not in IDLE
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- level  out  LVL_W  FIFO occupancy
- overflow  out  1  one-cycle pulse: write rejected because FIFO full
- tx_done  out  1  one-cycle pulse at end of each frame or break

Behaviour:
- Reset (arst high, async): tx=1, busy=0, full=0, empty=1, level=0, overflow=0, tx_done=0, FSM=IDLE, FIFO pointers cleared.
- FIFO writes:
  - A write is accepted when wr_en && !full, using the registered full value.
  - A write while full is dropped and pulses overflow the next cycle, even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Writes are accepted regardless of active.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK. All transitions occur only on cycles with tnsm_clk_en=1, except the active abort. tx is registered and reflects the new state one cycle after the transition.
- IDLE:
  - On tnsm_clk_en && active && break_req: go to BREAK (break has priority over FIFO data).
  - Else on tnsm_clk_en && active && !empty: pop the FIFO and go to START.
  - The pop latches payload, data_len, parity_type and stop_type. Config changes mid-frame have no effect.
- START: tx=0 for one bit period, then DATA.
- DATA: shift out bit 0 first. After len bits, go to PARITY if parity_type != 00, else STOP1. len = data_len clamped to [5, DATA_MAX].
- PARITY: tx = XOR of the len data bits (even), its inverse (odd), or 1 (mark). Then STOP1.
- STOP1: tx=1. Then STOP2 if the latched stop_type=1, else frame end.
- STOP2: tx=1, then frame end.
- Frame end (on tnsm_clk_en):
  - tx_done pulses.
  - If active && !empty && !break_req: pop and go directly to START (no idle bit).
  - Else if active && break_req: go to BREAK.
  - Else go to IDLE.
- BREAK: tx=0. On tnsm_clk_en with break_req=0, go to STOP1 using a single stop bit regardless of stop_type. tx_done pulses at the end of that STOP1.
- active low: FSM returns to IDLE on the next clk edge from any state. tx=1 and busy=0 one cycle later. The partially sent frame is discarded, no tx_done. FIFO contents are retained.
- busy = (state != IDLE). The pop and the rise of busy occur on the same edge.
- Invariants: tx=1 in IDLE, STOP1 and STOP2; full and empty never both high.

Decomposition:
- Package uart_pkg holds:
  - the state enum (STATE_TNSM_IDLE, _START, _DATA, _PARITY, _STOP1, _STOP2, _BREAK);
  - parity encodings PARITY_NONE/ODD/EVEN/MARK;
  - the STOP_ONE/STOP_TWO constants;
  - the DATA_MIN=5 constant.
- One sub-module, uart_sync_fifo (parametrised WIDTH and DEPTH, outputs full, empty, level). It is instantiated with WIDTH=DATA_MAX and DEPTH=FIFO_DEPTH.
- FSM, shift register, bit counter and parity logic stay in uart_tnsm_fifo.

Test Plan:
- Write 0xA5, data_len=8, parity even, one stop, tnsm_clk_en every 4 clks -> tx: 0, then 1,0,1,0,0,1,0,1, parity 0, stop 1; tx_done pulses once; empty=1, busy=0 afterwards.
- Write 0x1FF, data_len=9, parity odd, two stops -> nine 1s, parity 0, two stop bits; then data_len=3 with 0x07 -> five data bits sent (clamped).
- Write 3 bytes back-to-back -> three frames with no idle bit between STOP and START; level goes 3→2→1→0; three tx_done pulses.
- Write FIFO_DEPTH+1 entries while active=0 -> full=1, level=8, overflow pulses once; raise active -> all 8 frames sent in order.
- Drop active mid-DATA -> tx=1 and busy=0 within 2 clks, no tx_done, level unchanged.
- Assert break_req for 20 bit periods with FIFO non-empty -> tx low 20 bit periods, then one stop bit and tx_done, then queued frame starts; arst mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter slice.
//   tnsm_state_t  : transmitter FSM states
//   PARITY_*      : parity_type encodings
//   STOP_*        : stop_type encodings
//   DATA_MIN      : shortest legal data field
//   clamp_len()   : clamp a requested data length into [DATA_MIN, max_len]
package uart_pkg;

  typedef enum logic [2:0] {
    STATE_TNSM_IDLE,
    STATE_TNSM_START,
    STATE_TNSM_DATA,
    STATE_TNSM_PARITY,
    STATE_TNSM_STOP1,
    STATE_TNSM_STOP2,
    STATE_TNSM_BREAK
  } tnsm_state_t;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;
  localparam logic [1:0] PARITY_MARK = 2'b11;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  localparam int DATA_MIN = 5;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    if (len < 4'(DATA_MIN)) return 4'(DATA_MIN);
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered status flags.
//   clk, arst : clock, async active-high reset
//   wr_en     : write strobe, accepted only when !full
//   wr_data   : write payload
//   rd_en     : pop strobe, ignored when empty
//   rd_data   : head entry (valid while !empty)
//   full/empty/level : occupancy status
//   overflow  : one-cycle pulse after a write was dropped because full
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             push, pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + LW'(1);
    else if (pop && !push) level_nxt = level - LW'(1);
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level    <= level_nxt;
      full     <= (level_nxt == LW'(DEPTH));
      empty    <= (level_nxt == '0);
      // Judged on the registered full, so a pop in the same cycle does not save it.
      overflow <= wr_en && full;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tnsm_fifo.sv
// UART transmitter with built-in TX FIFO and break generator.
//   clk, arst     : clock, async active-high reset
//   active        : enable; dropping it aborts the current frame
//   wr_en/wr_data : FIFO write port
//   data_len, parity_type, stop_type : frame format, captured on each pop
//   break_req     : hold the line low while high
//   tnsm_clk_en   : one pulse per bit period
//   tx            : serial output, idle high
//   busy          : FSM not idle
//   full/empty/level/overflow : FIFO status
//   tx_done       : one-cycle pulse at the end of every frame or break
module uart_tnsm_fifo
  import uart_pkg::*;
#(
  parameter int DATA_MAX   = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                active,
  input  logic                wr_en,
  input  logic [DATA_MAX-1:0] wr_data,
  input  logic [3:0]          data_len,
  input  logic [1:0]          parity_type,
  input  logic                stop_type,
  input  logic                break_req,
  input  logic                tnsm_clk_en,
  output logic                tx,
  output logic                busy,
  output logic                full,
  output logic                empty,
  output logic [LVL_W-1:0]    level,
  output logic                overflow,
  output logic                tx_done
);

  localparam logic [3:0] LEN_MAX = 4'(DATA_MAX);

  tnsm_state_t         state;
  logic [DATA_MAX-1:0] shreg, fifo_data;
  logic [3:0]          len, cnt, pop_len;
  logic [1:0]          par_type;
  logic                stop_two, par_bit, pop_par, pop, frame_end, tx_nxt;

  uart_sync_fifo #(.WIDTH(DATA_MAX), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .arst     (arst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  assign busy      = (state != STATE_TNSM_IDLE);
  assign frame_end = (state == STATE_TNSM_STOP1 && stop_two == STOP_ONE) ||
                     (state == STATE_TNSM_STOP2);
  // Break beats queued data both from idle and at a frame boundary.
  assign pop = tnsm_clk_en && active && !empty && !break_req &&
               (state == STATE_TNSM_IDLE || frame_end);

  // Parity is computed once from the head entry at pop time, so the shift
  // register does not need to be replayed.
  always_comb begin
    pop_len = clamp_len(data_len, LEN_MAX);
    pop_par = 1'b0;
    for (int i = 0; i < DATA_MAX; i++)
      if (4'(i) < pop_len) pop_par = pop_par ^ fifo_data[i];
  end

  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      STATE_TNSM_START, STATE_TNSM_BREAK: tx_nxt = 1'b0;
      STATE_TNSM_DATA:                    tx_nxt = shreg[0];
      STATE_TNSM_PARITY:                  tx_nxt = par_bit;
      default:                            tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= STATE_TNSM_IDLE;
      shreg    <= '0;
      len      <= 4'(DATA_MIN);
      cnt      <= '0;
      par_type <= PARITY_NONE;
      stop_two <= STOP_ONE;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx      <= tx_nxt;
      tx_done <= 1'b0;
      if (pop) begin
        shreg    <= fifo_data;
        len      <= pop_len;
        cnt      <= '0;
        par_type <= parity_type;
        stop_two <= stop_type;
        par_bit  <= (parity_type == PARITY_MARK) ? 1'b1 :
                    (parity_type == PARITY_ODD)  ? ~pop_par : pop_par;
      end
      if (!active) begin
        state <= STATE_TNSM_IDLE;
      end else if (tnsm_clk_en) begin
        case (state)
          STATE_TNSM_IDLE:
            if (break_req) state <= STATE_TNSM_BREAK;
            else if (pop)  state <= STATE_TNSM_START;
          STATE_TNSM_START: state <= STATE_TNSM_DATA;
          STATE_TNSM_DATA: begin
            shreg <= shreg >> 1;
            cnt   <= cnt + 4'd1;
            if (cnt == len - 4'd1)
              state <= (par_type != PARITY_NONE) ? STATE_TNSM_PARITY : STATE_TNSM_STOP1;
          end
          STATE_TNSM_PARITY: state <= STATE_TNSM_STOP1;
          STATE_TNSM_STOP1, STATE_TNSM_STOP2:
            if (frame_end) begin
              tx_done <= 1'b1;
              if (pop)            state <= STATE_TNSM_START;
              else if (break_req) state <= STATE_TNSM_BREAK;
              else                state <= STATE_TNSM_IDLE;
            end else begin
              state <= STATE_TNSM_STOP2;
            end
          STATE_TNSM_BREAK:
            // Leaving break always uses a single stop bit.
            if (!break_req) begin
              stop_two <= STOP_ONE;
              state    <= STATE_TNSM_STOP1;
            end
          default: state <= STATE_TNSM_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tnsm_fifo.sv
module tb_uart_tnsm_fifo;
  localparam int DATA_MAX   = 9;
  localparam int FIFO_DEPTH = 8;
  localparam int LVL_W      = 4;

  logic clk = 1'b0, arst = 1'b1, active = 1'b0, wr_en = 1'b0;
  logic [DATA_MAX-1:0] wr_data = '0;
  logic [3:0] data_len = 4'd8;
  logic [1:0] parity_type = 2'b00;
  logic stop_type = 1'b0, break_req = 1'b0, tnsm_clk_en = 1'b0;
  logic tx, busy, full, empty, overflow, tx_done;
  logic [LVL_W-1:0] level;

  int tests = 0, fails = 0;
  int period = 4, en_cnt = 0;
  int done_cnt = 0, ovf_cnt = 0, busy_drop = 0;
  logic busy_d = 1'b0;
  logic [LVL_W-1:0] last_lvl = '0;
  bit cap[$];
  bit exp_q[$];
  int lvl_q[$];

  typedef struct {
    logic [8:0] data;
    logic [3:0] dl;
    logic [1:0] par;
    logic       stp;
    string      bits;
  } vec_t;
  vec_t vecs[6];

  uart_tnsm_fifo #(.DATA_MAX(DATA_MAX), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .arst(arst), .active(active), .wr_en(wr_en), .wr_data(wr_data),
    .data_len(data_len), .parity_type(parity_type), .stop_type(stop_type),
    .break_req(break_req), .tnsm_clk_en(tnsm_clk_en), .tx(tx), .busy(busy),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Bit-rate enable: one pulse every 'period' clocks, driven just after the edge.
  initial begin
    forever begin
      @(posedge clk); #2;
      en_cnt++;
      if (en_cnt >= period) begin tnsm_clk_en = 1'b1; en_cnt = 0; end
      else tnsm_clk_en = 1'b0;
    end
  end

  // Line monitor: the bit held during each bit period is sampled on the
  // cycle that ends the period.
  always @(negedge clk) begin
    if (tnsm_clk_en && busy) cap.push_back(tx);
    if (tx_done) done_cnt++;
    if (overflow) ovf_cnt++;
    if (busy_d && !busy) busy_drop++;
    busy_d = busy;
    if (level != last_lvl) lvl_q.push_back(int'(level));
    last_lvl = level;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bits(input string name);
    string a = "", e = "";
    bit ok = (cap.size() == exp_q.size());
    foreach (exp_q[i]) begin
      if (i < 200) e = {e, exp_q[i] ? "1" : "0"};
      if (i < cap.size() && cap[i] != exp_q[i]) ok = 1'b0;
    end
    foreach (cap[i]) if (i < 200) a = {a, cap[i] ? "1" : "0"};
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: line %s expected %s", name, a, e);
    end
  endtask

  // Reference frame: start, len data bits LSB first, optional parity, stops.
  function automatic void model_frame(input int d, input int dl, input int par, input int stp);
    int n = (dl < 5) ? 5 : ((dl > DATA_MAX) ? DATA_MAX : dl);
    bit x = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bit b = ((d >> i) & 1) != 0;
      exp_q.push_back(b);
      x = x ^ b;
    end
    if (par == 1) exp_q.push_back(!x);
    else if (par == 2) exp_q.push_back(x);
    else if (par == 3) exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    if (stp != 0) exp_q.push_back(1'b1);
  endfunction

  function automatic void str_frame(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == 8'h31);
  endfunction

  task automatic write(input logic [8:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(); n++; end
    check({name, " tx_done count"}, done_cnt, target);
  endtask

  task automatic wait_cap(input int sz, input int budget);
    int n = 0;
    while (cap.size() < sz && n < budget) begin tick(); n++; end
  endtask

  // One frame through an idle, active transmitter; exp_q must be prepared.
  task automatic run_frame(input string name, input logic [8:0] d, input logic [3:0] dl,
                           input logic [1:0] par, input logic stp);
    int d0 = done_cnt;
    data_len = dl; parity_type = par; stop_type = stp;
    cap.delete();
    write(d);
    wait_done(d0 + 1, 800, name);
    repeat (2 * period) tick();
    check_bits(name);
    check({name, " empty"}, empty, 1);
    check({name, " busy"}, busy, 0);
    check({name, " single tx_done"}, done_cnt, d0 + 1);
  endtask

  initial begin
    int d0, o0, b0, code;
    logic [8:0] vals[9];

    vecs[0] = '{9'h0A5, 4'd8,  2'b10, 1'b0, "01010010101"};
    vecs[1] = '{9'h1FF, 4'd9,  2'b01, 1'b1, "0111111111011"};
    vecs[2] = '{9'h007, 4'd3,  2'b00, 1'b0, "0111001"};
    vecs[3] = '{9'h0C3, 4'd7,  2'b11, 1'b1, "01100001111"};
    vecs[4] = '{9'h155, 4'd15, 2'b10, 1'b0, "010101010111"};
    vecs[5] = '{9'h000, 4'd6,  2'b01, 1'b0, "000000011"};

    // Reset values
    repeat (3) tick();
    check("rst tx", tx, 1);
    check("rst busy", busy, 0);
    check("rst full", full, 0);
    check("rst empty", empty, 1);
    check("rst level", level, 0);
    check("rst overflow", overflow, 0);
    check("rst tx_done", tx_done, 0);
    arst = 1'b0;
    active = 1'b1;
    repeat (2) tick();

    // Directed frame table
    foreach (vecs[k]) begin
      exp_q.delete();
      str_frame(vecs[k].bits);
      run_frame($sformatf("vec%0d", k), vecs[k].data, vecs[k].dl, vecs[k].par, vecs[k].stp);
    end

    // Three back-to-back frames, no idle bit between them
    active = 1'b0; data_len = 4'd8; parity_type = 2'b10; stop_type = 1'b0;
    tick();
    wr_en = 1'b1;
    wr_data = 9'h011; tick();
    wr_data = 9'h022; tick();
    wr_data = 9'h033; tick();
    wr_en = 1'b0;
    tick();
    check("b2b level", level, 3);
    lvl_q.delete(); cap.delete(); exp_q.delete();
    model_frame(9'h011, 8, 2, 0); model_frame(9'h022, 8, 2, 0); model_frame(9'h033, 8, 2, 0);
    b0 = busy_drop; d0 = done_cnt;
    active = 1'b1;
    wait_done(d0 + 3, 800, "b2b");
    repeat (2 * period) tick();
    check_bits("b2b line");
    code = 0;
    foreach (lvl_q[i]) code = code * 10 + lvl_q[i];
    check("b2b level trace", code, 210);
    check("b2b busy drops", busy_drop - b0, 1);

    // Overflow while inactive, then drain in order
    active = 1'b0; period = 2; parity_type = 2'b00; stop_type = 1'b0; data_len = 4'd8;
    tick();
    o0 = ovf_cnt;
    for (int i = 0; i < 9; i++) begin
      vals[i] = 9'($urandom_range(0, 511));
      wr_en = 1'b1; wr_data = vals[i];
      tick();
    end
    wr_en = 1'b0;
    repeat (2) tick();
    check("ovf full", full, 1);
    check("ovf level", level, 8);
    check("ovf empty", empty, 0);
    check("ovf pulses", ovf_cnt - o0, 1);
    cap.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) model_frame(int'(vals[i]), 8, 0, 0);
    d0 = done_cnt;
    active = 1'b1;
    wait_done(d0 + 8, 1500, "ovf drain");
    repeat (2 * period) tick();
    check_bits("ovf drain line");
    check("ovf drain empty", empty, 1);

    // Abort mid-DATA
    active = 1'b0; period = 4;
    tick();
    wr_en = 1'b1;
    wr_data = 9'h05A; tick();
    wr_data = 9'h03C; tick();
    wr_en = 1'b0;
    cap.delete();
    d0 = done_cnt;
    active = 1'b1;
    wait_cap(4, 200);
    active = 1'b0;
    tick(); tick();
    check("abort tx", tx, 1);
    check("abort busy", busy, 0);
    check("abort level", level, 1);
    repeat (10) tick();
    check("abort no tx_done", done_cnt, d0);
    cap.delete(); exp_q.delete();
    model_frame(9'h03C, 8, 0, 0);
    active = 1'b1;
    wait_done(d0 + 1, 800, "abort resume");
    repeat (2 * period) tick();
    check_bits("abort resume line");

    // Break for 20 bit periods with a frame queued
    active = 1'b0; data_len = 4'd8; parity_type = 2'b10; stop_type = 1'b1;
    tick();
    write(9'h03C);
    break_req = 1'b1;
    cap.delete(); exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    model_frame(9'h03C, 8, 2, 1);
    d0 = done_cnt;
    active = 1'b1;
    wait_cap(19, 400);
    break_req = 1'b0;
    wait_done(d0 + 2, 800, "break");
    repeat (2 * period) tick();
    check_bits("break line");

    // Randomized single frames against the reference model
    for (int r = 0; r < 10; r++) begin
      int d, dl, par, stp;
      period = $urandom_range(2, 6);
      d = $urandom_range(0, 511); dl = $urandom_range(0, 15);
      par = $urandom_range(0, 3); stp = $urandom_range(0, 1);
      exp_q.delete();
      model_frame(d, dl, par, stp);
      run_frame($sformatf("rand%0d", r), 9'(d), 4'(dl), 2'(par), 1'(stp));
    end

    // Async reset in the middle of a frame
    active = 1'b0; period = 4;
    tick();
    wr_en = 1'b1;
    repeat (3) begin wr_data = 9'($urandom_range(0, 511)); tick(); end
    wr_en = 1'b0;
    cap.delete();
    active = 1'b1;
    wait_cap(3, 200);
    arst = 1'b1;
    #1;
    check("arst tx", tx, 1);
    check("arst busy", busy, 0);
    check("arst full", full, 0);
    check("arst empty", empty, 1);
    check("arst level", level, 0);
    check("arst overflow", overflow, 0);
    check("arst tx_done", tx_done, 0);
    tick();
    arst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
